// File: rtl/gbf_fill_controller_if.sv
// Upstream beat stream into the GBF fill controller.
// Ports: in_valid/in_data (source -> controller), in_ready (controller -> source).
interface gbf_fill_controller_if #(
  parameter int GBF_DATA_BITWIDTH = 512
);
  logic                         in_valid;
  logic [GBF_DATA_BITWIDTH-1:0] in_data;
  logic                         in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/gbf_fill_controller.sv
// Fills the two GBF buffers on need_data1/2 from an upstream valid/ready stream.
// Ports: clk, reset (sync, high), finish, fill_len, need_data1/2, up (stream slave),
// en/we/addr/w_data for port A of both buffers, buf1/2_ready, data_avail.
// Optional: define GBF_FILL_STALL_CNT_EN to add the stall_cnt[31:0] output.
module gbf_fill_controller #(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         finish,
  input  logic [GBF_ADDR_BITWIDTH:0]   fill_len,
  input  logic                         need_data1,
  input  logic                         need_data2,
  gbf_fill_controller_if.slave         up,
  output logic                         en1a,
  output logic                         we1a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
  output logic                         en2a,
  output logic                         we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
  output logic                         buf1_ready,
  output logic                         buf2_ready,
  output logic                         data_avail
`ifdef GBF_FILL_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int AW = GBF_ADDR_BITWIDTH;

  typedef logic [AW:0] cnt_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL1,
    S_FILL2,
    S_DONE
  } state_t;

  localparam cnt_t DEPTH_C = GBF_DEPTH[AW:0];
  localparam cnt_t CNT_ONE = cnt_t'(1);

  state_t     state;
  logic       pend1, pend2;
  logic       abort;
  logic       rdy_q;
  logic [1:0] last_filled;
  cnt_t       count;
  cnt_t       len;

  logic fill1, fill2, hs, last_hs;
  logic cap1, cap2, req1, req2;
  logic pick2, start;
  cnt_t len_in;

  assign fill1   = (state == S_FILL1);
  assign fill2   = (state == S_FILL2);
  assign hs      = up.in_valid && (fill1 || fill2);
  assign last_hs = hs && (count == len - CNT_ONE);

  // A need seen in the same cycle is acted on directly, so an
  // idle controller starts filling on the very next edge.
  assign cap1 = need_data1 && !fill1;
  assign cap2 = need_data2 && !fill2;
  assign req1 = !finish && (pend1 || cap1);
  assign req2 = !finish && (pend2 || cap2);

  // Round-robin: with both requests live, skip the last-filled buffer.
  assign pick2 = req2 && (!req1 || last_filled == 2'd1);
  assign start = (state == S_IDLE || state == S_DONE) && (req1 || req2);

  assign len_in = (fill_len == '0 || fill_len > DEPTH_C) ?
                  DEPTH_C : fill_len;

  assign up.in_ready = rdy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pend1       <= 1'b0;
      pend2       <= 1'b0;
      abort       <= 1'b0;
      rdy_q       <= 1'b0;
      last_filled <= 2'd2;
      count       <= '0;
      len         <= '0;
      en1a        <= 1'b0;
      we1a        <= 1'b0;
      addr1a      <= '0;
      w_data1a    <= '0;
      en2a        <= 1'b0;
      we2a        <= 1'b0;
      addr2a      <= '0;
      w_data2a    <= '0;
      buf1_ready  <= 1'b0;
      buf2_ready  <= 1'b0;
      data_avail  <= 1'b0;
    end else begin
      en1a  <= 1'b0;
      we1a  <= 1'b0;
      en2a  <= 1'b0;
      we2a  <= 1'b0;
      pend1 <= req1;
      pend2 <= req2;
      if (cap1 || finish) buf1_ready <= 1'b0;
      if (cap2 || finish) buf2_ready <= 1'b0;
      if (finish) data_avail <= 1'b0;

      if (hs) begin
        count <= count + CNT_ONE;
        if (fill1) begin
          en1a     <= 1'b1;
          we1a     <= 1'b1;
          addr1a   <= count[AW-1:0];
          w_data1a <= up.in_data;
        end else begin
          en2a     <= 1'b1;
          we2a     <= 1'b1;
          addr2a   <= count[AW-1:0];
          w_data2a <= up.in_data;
        end
      end

      unique case (state)
        S_IDLE, S_DONE: begin
          rdy_q <= start;
          if (!start) begin
            state <= S_IDLE;
          end else begin
            abort <= 1'b0;
            count <= '0;
            len   <= len_in;
            if (pick2) begin
              state <= S_FILL2;
              pend2 <= 1'b0;
            end else begin
              state <= S_FILL1;
              pend1 <= 1'b0;
            end
          end
        end
        S_FILL1, S_FILL2: begin
          // finish lets the fill run to length but suppresses ready.
          if (finish) abort <= 1'b1;
          if (last_hs) begin
            state       <= S_DONE;
            rdy_q       <= 1'b0;
            last_filled <= fill2 ? 2'd2 : 2'd1;
            if (!abort && !finish) begin
              data_avail <= 1'b1;
              if (fill1) buf1_ready <= 1'b1;
              else       buf2_ready <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GBF_FILL_STALL_CNT_EN
  logic stall;

  assign stall = ((fill1 || fill2) && !up.in_valid) ||
                 (state == S_IDLE && (pend1 || pend2));

  always_ff @(posedge clk) begin
    if (reset || finish) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
